// File: rtl/uart_mmio_rx_if.sv
// Word-addressed data-memory bus between the CPU and the UART receiver register block.
interface uart_mmio_rx_if;
   logic [11:0] addr;
   logic        rEn;
   logic        wEn;
   logic [31:0] dataIn;
   logic [31:0] dataOut;
   logic        hit;

   modport master (output addr, rEn, wEn, dataIn, input dataOut, hit);
   modport slave  (input addr, rEn, wEn, dataIn, output dataOut, hit);
endinterface

// File: rtl/uart_mmio_rx.sv
// Oversampling UART receiver with a receive FIFO and a 4-word register block
// (DATA, STATUS, CTRL, reserved) mapped at BASE_ADDR on the dmem bus.
module uart_mmio_rx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter logic [11:0] BASE_ADDR    = 12'hF00
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           serialIn,
   uart_mmio_rx_if.slave  bus,
   output logic           rxAvail,
   output logic           irq,
   output logic [7:0]     lastByte
);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_FW = PTR_W + 1;
   localparam logic [CNT_W-1:0]  HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
   localparam logic [CNT_W-1:0]  FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [2:0]        LAST_BIT = 3'(DATA_BITS - 1);
   localparam logic [CNT_FW-1:0] FULL_CNT = CNT_FW'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_e;

   rx_state_e         state_q, state_d;
   logic [1:0]        sync_q, sync_d;
   logic              rx_prev_q, rx_prev_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              par_bad_q, par_bad_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CNT_FW-1:0] count_q, count_d;
   logic              parity_err_q, parity_err_d, frame_err_q, frame_err_d;
   logic              overrun_err_q, overrun_err_d;
   logic              irq_on_data_q, irq_on_data_d, irq_on_err_q, irq_on_err_d;
   logic [31:0]       data_out_q, data_out_d;
   logic              hit_q, hit_d;
   logic [7:0]        last_byte_q, last_byte_d;
   logic [7:0]        fifo_mem [FIFO_DEPTH];

   logic        rx, fall, exp_par, push, push_ok, pop, flush, full, empty;
   logic        set_par, set_frame, wr_status, wr_ctrl, in_range;
   logic [11:0] offset;
   logic [1:0]  reg_sel;
   logic [31:0] rd_data;
   logic        unused_din;

   assign rx         = sync_q[1];
   assign fall       = rx_prev_q & ~rx;
   assign exp_par    = (PARITY == 2) ? ~(^shift_q) : ^shift_q;
   assign full       = (count_q == FULL_CNT);
   assign empty      = (count_q == '0);
   assign offset     = bus.addr - BASE_ADDR;
   assign in_range   = (offset < 12'd4);
   assign reg_sel    = offset[1:0];
   assign pop        = bus.rEn & in_range & (reg_sel == 2'd0) & ~empty;
   assign wr_status  = bus.wEn & in_range & (reg_sel == 2'd1);
   assign wr_ctrl    = bus.wEn & in_range & (reg_sel == 2'd2);
   assign flush      = wr_ctrl & bus.dataIn[2];
   assign unused_din = ^bus.dataIn[31:3];

   // Receive FSM: samples mid-bit by counting down from the detected falling edge.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      par_bad_d   = par_bad_q;
      last_byte_d = last_byte_q;
      push        = 1'b0;
      set_par     = 1'b0;
      set_frame   = 1'b0;
      case (state_q)
         S_IDLE: if (fall) begin
            cnt_d   = HALF_BIT;
            state_d = S_START;
         end
         S_START: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                  else if (!rx) begin
                     state_d   = S_DATA;
                     cnt_d     = FULL_BIT;
                     bit_idx_d = '0;
                     shift_d   = '0;
                     par_bad_d = 1'b0;
                  end else state_d = S_IDLE;
         S_DATA: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                 else begin
                    shift_d[bit_idx_q] = rx;
                    cnt_d              = FULL_BIT;
                    bit_idx_d          = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_BIT) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                 end
         S_PARITY: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                   else begin
                      par_bad_d = (rx != exp_par);
                      set_par   = (rx != exp_par);
                      cnt_d     = FULL_BIT;
                      state_d   = S_STOP;
                   end
         S_STOP: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                 else begin
                    last_byte_d = shift_q;
                    set_frame   = ~rx;
                    push        = rx & ~par_bad_q;
                    state_d     = S_IDLE;
                 end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO, sticky errors and the register block.
   always_comb begin
      sync_d    = {sync_q[0], serialIn};
      rx_prev_d = rx;
      // Push while full only succeeds when a pop frees the slot in the same cycle.
      push_ok   = push & (~full | pop);
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      count_d   = count_q + CNT_FW'(push_ok) - CNT_FW'(pop);
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end

      parity_err_d  = (parity_err_q  & ~(wr_status & bus.dataIn[0])) | set_par;
      frame_err_d   = (frame_err_q   & ~(wr_status & bus.dataIn[1])) | set_frame;
      overrun_err_d = (overrun_err_q & ~(wr_status & bus.dataIn[2])) | (push & ~push_ok);

      irq_on_data_d = wr_ctrl ? bus.dataIn[0] : irq_on_data_q;
      irq_on_err_d  = wr_ctrl ? bus.dataIn[1] : irq_on_err_q;

      case (reg_sel)
         2'd0:    rd_data = empty ? 32'h0 : {1'b1, 23'b0, fifo_mem[rd_ptr_q]};
         2'd1:    rd_data = {16'b0, 8'(count_q), 4'b0, full, overrun_err_q, frame_err_q, parity_err_q};
         2'd2:    rd_data = {30'b0, irq_on_err_q, irq_on_data_q};
         default: rd_data = 32'h0;
      endcase
      data_out_d = (bus.rEn & in_range) ? rd_data : data_out_q;
      hit_d      = (bus.rEn | bus.wEn) ? in_range : hit_q;
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (reset) begin
         state_q       <= S_IDLE;
         sync_q        <= 2'b11;
         rx_prev_q     <= 1'b1;
         cnt_q         <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         par_bad_q     <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         parity_err_q  <= 1'b0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
         irq_on_data_q <= 1'b0;
         irq_on_err_q  <= 1'b0;
         data_out_q    <= '0;
         hit_q         <= 1'b0;
         last_byte_q   <= '0;
      end else begin
         state_q       <= state_d;
         sync_q        <= sync_d;
         rx_prev_q     <= rx_prev_d;
         cnt_q         <= cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         par_bad_q     <= par_bad_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         parity_err_q  <= parity_err_d;
         frame_err_q   <= frame_err_d;
         overrun_err_q <= overrun_err_d;
         irq_on_data_q <= irq_on_data_d;
         irq_on_err_q  <= irq_on_err_d;
         data_out_q    <= data_out_d;
         hit_q         <= hit_d;
         last_byte_q   <= last_byte_d;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= shift_q;
   end

   assign bus.dataOut = data_out_q;
   assign bus.hit     = hit_q;
   assign rxAvail     = ~empty;
   assign irq         = (irq_on_data_q & rxAvail) |
                        (irq_on_err_q & (parity_err_q | frame_err_q | overrun_err_q));
   assign lastByte    = last_byte_q;
endmodule
